updown_counter_axil_slave: RTL and testbench
============================================

Name: updown_counter_axil_slave

Overview:
- AXI4-Lite slave end of the S00_AXI interface of the upDownCounter IP. It is the responder to the AXI VIP master in the block-design bench.
- Holds four 32-bit registers that control a programmable up/down counter with load, limit/wrap and a sticky wrap flag.
- Exports the live count and a wrap pulse to fabric.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S00_AXI_ADDR_WIDTH, 4, AXI address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_aresetn  in  1  asynchronous, active-low reset
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid/s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid/s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  always 2'b00 (OKAY)
s00_axi_bvalid/s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid/s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 2'b00
s00_axi_rvalid/s00_axi_rready  out/in  1  R handshake
count_out  out  32  current counter value (registered)
wrap_pulse  out  1  high for one cycle on each wrap

Behaviour:
- Reset: asynchronous on aresetn=0, released synchronously by design. While asserted and after release:
  - all ready/valid outputs = 0; rdata = 0
  - CTRL = 0, LOADVAL = 0, LIMIT = 0xFFFFFFFF, count = 0, WRAP flag = 0, wrap_pulse = 0
  - any in-flight transaction is dropped; the master must reissue it.
- Register map:
  - 0x0 CTRL:
    - bit0 EN (RW)
    - bit1 UP (RW; 1 = up, 0 = down)
    - bit2 LOAD (write 1 = one-shot load; always reads 0)
    - bit8 WRAP (sticky; write 1 to clear)
    - other bits read 0
  - 0x4 LOADVAL (RW)
  - 0x8 LIMIT (RW)
  - 0xC COUNT: read-only. Writes are accepted with OKAY and have no effect.
- Write channel:
  - awready and wready are asserted together for exactly one cycle when awvalid=1, wvalid=1 and bvalid=0. Address and data are latched in that cycle.
  - AW without W, or W without AW: nothing is accepted; the block waits.
  - bvalid rises the cycle after acceptance and holds until bready=1. No new write is accepted while bvalid=1.
  - wstrb is honoured per byte on CTRL, LOADVAL and LIMIT. LOAD and WRAP-clear act only if wstrb[0] / wstrb[1] respectively is set.
- Read channel:
  - arready is a one-cycle pulse when arvalid=1 and rvalid=0.
  - rvalid and rdata are driven the next cycle and held stable until rready=1.
  - COUNT reads return the value sampled in the arready cycle.
- Read and write channels are independent and may complete in the same cycle.
- Counter, evaluated each cycle in this priority order:
  1. LOAD written this cycle: count <= LOADVAL (the value before this write, if LOADVAL is also written); no wrap.
  2. EN=1, UP=1: if count == LIMIT, count <= 0, wrap_pulse = 1 and WRAP is set; else count <= count+1.
  3. EN=1, UP=0: if count == 0, count <= LIMIT, wrap_pulse = 1 and WRAP is set; else count <= count-1.
  4. Otherwise count holds.
- Write-to-effect timing: a CTRL write takes effect on the cycle after the awready cycle. LOAD acts in the awready cycle, so the new count is visible one cycle later.
- count > LIMIT (after a load or a LIMIT write) in up mode: keep incrementing through 0xFFFFFFFF. 0xFFFFFFFF -> 0 is a wrap only if LIMIT = 0xFFFFFFFF; otherwise it is plain modulo-2^32 rollover with no flag.
- Same cycle as a wrap: a W1C clear of WRAP loses; WRAP stays set.
- LIMIT = 0: count stays 0 and wraps every enabled cycle, in either direction.
- count_out is count registered, with zero added latency.

Test Plan:
- Reset: hold aresetn=0 for 100 ns -> after release, read 0x0=0, 0x4=0, 0x8=0xFFFFFFFF, 0xC=0; bvalid and rvalid stay 0 throughout.
- Write/read-back: write 0x4=0x12345678, 0x8=0x0000000A; read both back exactly; write 0xC=0xDEAD then read 0xC -> 0.
- Up wrap: LIMIT=3, CTRL=0x3 -> count sequence 0,1,2,3,0; wrap_pulse high 1 cycle at 3->0; CTRL reads 0x103; write CTRL=0x103 -> reads 0x003.
- Down/load: LOADVAL=2, write CTRL=0x4 then CTRL=0x1 with LIMIT=5 -> count 2,1,0,5,4; LOAD bit reads 0.
- Strobes: write 0x4=0xAABBCCDD with wstrb=4'b0101 over 0 -> reads 0x00BB00DD.
- Backpressure/ordering: AW 5 cycles before W -> single accept on the W cycle; bready held 0 for 4 cycles -> bvalid held and a second write not accepted. Reset asserted mid-read -> rvalid drops to 0 immediately.

Source files
------------

// File: rtl/updown_counter_axil_slave.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_axil_slave
// Description : AXI4-Lite slave with four registers driving a programmable
//               up/down counter with load, limit/wrap and a sticky wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_axil_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [31:0]                       count_out,
  output logic                              wrap_pulse
);

  localparam logic [1:0] c_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] c_ADDR_LOADVAL = 2'd1;
  localparam logic [1:0] c_ADDR_LIMIT   = 2'd2;
  localparam logic [1:0] c_ADDR_COUNT   = 2'd3;

  logic        r_awready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_en;
  logic        r_up;
  logic        r_wrap_flag;
  logic [31:0] r_loadval;
  logic [31:0] r_limit;
  logic [31:0] r_count;
  logic        r_wrap_pulse;

  logic        w_wr_en;
  logic [1:0]  w_wr_sel;
  logic [1:0]  w_rd_sel;
  logic        w_load;
  logic        w_wrap_clr;
  logic        w_wrap;
  logic [31:0] w_count_nxt;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Address and data are sampled while awready is high; the master must
  // keep them stable until the handshake completes.
  assign w_wr_en    = r_awready;
  assign w_wr_sel   = s00_axi_awaddr[3:2];
  assign w_rd_sel   = s00_axi_araddr[3:2];
  assign w_load     = w_wr_en && (w_wr_sel == c_ADDR_CTRL) &&
                      s00_axi_wstrb[0] && s00_axi_wdata[2];
  assign w_wrap_clr = w_wr_en && (w_wr_sel == c_ADDR_CTRL) &&
                      s00_axi_wstrb[1] && s00_axi_wdata[8];

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // AXI handshakes
  // -------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_awready <= s00_axi_awvalid && s00_axi_wvalid && !r_bvalid && !r_awready;
      if (r_awready)
        r_bvalid <= 1'b1;
      else if (s00_axi_bready)
        r_bvalid <= 1'b0;

      r_arready <= s00_axi_arvalid && !r_rvalid && !r_arready;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    case (w_rd_sel)
      c_ADDR_CTRL:    w_rd_data = {23'd0, r_wrap_flag, 6'd0, r_up, r_en};
      c_ADDR_LOADVAL: w_rd_data = r_loadval;
      c_ADDR_LIMIT:   w_rd_data = r_limit;
      c_ADDR_COUNT:   w_rd_data = r_count;
      default:        w_rd_data = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_en      <= 1'b0;
      r_up      <= 1'b0;
      r_loadval <= 32'd0;
      r_limit   <= 32'hFFFF_FFFF;
    end else if (w_wr_en) begin
      case (w_wr_sel)
        c_ADDR_CTRL: begin
          if (s00_axi_wstrb[0]) begin
            r_en <= s00_axi_wdata[0];
            r_up <= s00_axi_wdata[1];
          end
        end
        c_ADDR_LOADVAL: r_loadval <= f_merge(r_loadval, s00_axi_wdata, s00_axi_wstrb);
        c_ADDR_LIMIT:   r_limit   <= f_merge(r_limit, s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Counter: load beats enable; wrap happens only at LIMIT (up) or 0 (down)
  // -------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    w_wrap      = 1'b0;
    if (w_load) begin
      w_count_nxt = r_loadval;
    end else if (r_en) begin
      if (r_up) begin
        if (r_count == r_limit) begin
          w_count_nxt = 32'd0;
          w_wrap      = 1'b1;
        end else begin
          w_count_nxt = r_count + 32'd1;
        end
      end else begin
        if (r_count == 32'd0) begin
          w_count_nxt = r_limit;
          w_wrap      = 1'b1;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
    end
  end

  // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_count      <= 32'd0;
      r_wrap_pulse <= 1'b0;
      r_wrap_flag  <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_wrap_pulse <= w_wrap;
      if (w_wrap)
        r_wrap_flag <= 1'b1;
      else if (w_wrap_clr)
        r_wrap_flag <= 1'b0;
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign count_out       = r_count;
  assign wrap_pulse      = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_axil_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_axil_slave
// Description : Directed self-checking bench for updown_counter_axil_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_axil_slave;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] count_out;
  logic        wrap_pulse;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  updown_counter_axil_slave #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .count_out       (count_out),
    .wrap_pulse      (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(awready && wready) && n < 20);
    check("wr_accept", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", bvalid, 1'b1);
    check("wr_bresp", bresp, 2'b00);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    check("rd_accept", arready, 1'b1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", rvalid, 1'b1);
    check("rd_rresp", rresp, 2'b00);
    data = rdata;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; awaddr = 4'h0; awprot = 3'd0; wdata = 32'd0; wstrb = 4'hF;
    araddr = 4'h0; arprot = 3'd0; bready = 1'b0; rready = 1'b0;
    // Valids held high during reset: nothing may respond.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_quiet", {awready, wready, bvalid, arready, rvalid}, 5'd0);
    end
    check("rst_rdata", rdata, 32'd0);
    check("rst_count", count_out, 32'd0);
    check("rst_pulse", wrap_pulse, 1'b0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_quiet", {bvalid, rvalid}, 2'd0);
    axi_read(4'h0, rd); check("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("rst_loadval", rd, 32'h0);
    axi_read(4'h8, rd); check("rst_limit", rd, 32'hFFFF_FFFF);
    axi_read(4'hC, rd); check("rst_countreg", rd, 32'h0);

    // Write / read-back, COUNT is read-only
    axi_write(4'h4, 32'h1234_5678, 4'hF);
    axi_write(4'h8, 32'h0000_000A, 4'hF);
    axi_read(4'h4, rd); check("rb_loadval", rd, 32'h1234_5678);
    axi_read(4'h8, rd); check("rb_limit", rd, 32'h0000_000A);
    axi_write(4'hC, 32'h0000_DEAD, 4'hF);
    axi_read(4'hC, rd); check("count_ro", rd, 32'h0);

    // Byte strobes
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0101);
    axi_read(4'h4, rd); check("strobe", rd, 32'h00BB_00DD);

    // Up count with wrap at LIMIT=3
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    check("up_c1", count_out, 32'd1);
    tick(); check("up_c2", count_out, 32'd2);
    tick(); check("up_c3", count_out, 32'd3);
    check("up_nopulse", wrap_pulse, 1'b0);
    tick(); check("up_wrap", count_out, 32'd0);
    check("up_pulse", wrap_pulse, 1'b1);
    tick(); check("up_after", count_out, 32'd1);
    check("up_pulse_one", wrap_pulse, 1'b0);
    axi_read(4'h0, rd); check("ctrl_wrap_set", rd, 32'h103);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_read(4'h0, rd); check("ctrl_sticky", rd, 32'h100);
    axi_write(4'h0, 32'h100, 4'b0001);
    axi_read(4'h0, rd); check("w1c_needs_strb1", rd, 32'h100);
    axi_write(4'h0, 32'h100, 4'hF);
    axi_read(4'h0, rd); check("w1c_clear", rd, 32'h0);

    // Down count with load, LIMIT=5
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd5, 4'hF);
    axi_write(4'h0, 32'h4, 4'hF);
    check("load_val", count_out, 32'd2);
    axi_read(4'h0, rd); check("load_reads0", rd, 32'h0);
    axi_write(4'h0, 32'h1, 4'hF);
    check("dn_c1", count_out, 32'd1);
    tick(); check("dn_c0", count_out, 32'd0);
    tick(); check("dn_wrap", count_out, 32'd5);
    check("dn_pulse", wrap_pulse, 1'b1);
    tick(); check("dn_c4", count_out, 32'd4);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h0, 32'h100, 4'hF);
    axi_read(4'h0, rd); check("dn_ctrl", rd, 32'h0);

    // count above LIMIT rolls over through 0xFFFFFFFF without a wrap
    axi_write(4'h4, 32'hFFFF_FFFE, 4'hF);
    axi_write(4'h0, 32'h4, 4'hF);
    check("hi_load", count_out, 32'hFFFF_FFFE);
    axi_write(4'h0, 32'h3, 4'hF);
    check("hi_ff", count_out, 32'hFFFF_FFFF);
    tick(); check("hi_roll", count_out, 32'd0);
    check("hi_nopulse", wrap_pulse, 1'b0);
    tick(); check("hi_c1", count_out, 32'd1);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_read(4'h0, rd); check("hi_noflag", rd, 32'h0);

    // LIMIT=0: wraps every enabled cycle; W1C loses against a wrap
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'h4, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    check("l0_count", count_out, 32'd0);
    check("l0_pulse", wrap_pulse, 1'b1);
    tick(); check("l0_pulse2", wrap_pulse, 1'b1);
    axi_write(4'h0, 32'h101, 4'hF);
    check("l0_down_count", count_out, 32'd0);
    axi_read(4'h0, rd); check("w1c_loses", rd, 32'h101);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h0, 32'h100, 4'hF);
    axi_read(4'h0, rd); check("l0_cleared", rd, 32'h0);

    // AW leads W by 5 cycles; B backpressure blocks a second write
    awaddr = 4'h4; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check("aw_only_wait", {awready, wready}, 2'b00);
    end
    wvalid = 1'b1;
    tick(); check("w_arrive_accept", {awready, wready}, 2'b11);
    tick(); check("single_accept", awready, 1'b0);
    check("bp_bvalid", bvalid, 1'b1);
    wdata = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold", {bvalid, awready}, 2'b10);
    end
    bready = 1'b1;
    tick(); bready = 1'b0;
    check("bp_bdone", bvalid, 1'b0);
    tick(); check("second_accept", awready, 1'b1);
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    check("second_bvalid", bvalid, 1'b1);
    bready = 1'b1;
    tick(); bready = 1'b0;
    axi_read(4'h4, rd); check("bp_data", rd, 32'h2222_2222);

    // Reset asserted while a read response is pending
    araddr = 4'h8; arvalid = 1'b1;
    tick(); check("mr_arready", arready, 1'b1);
    tick(); arvalid = 1'b0;
    check("mr_rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("mr_rvalid_drop", rvalid, 1'b0);
    check("mr_rdata_zero", rdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    axi_read(4'h8, rd); check("mr_limit_reset", rd, 32'hFFFF_FFFF);
    axi_read(4'h4, rd); check("mr_loadval_reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
